mac_accumulator: RTL

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_accumulator_if.sv | 39 +++
 rtl/mac_accumulator_sat_add.sv | 38 +++
 rtl/mac_accumulator.sv | 110 +++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared constants and types for the MAC accumulator slice.
//   MAC_PROD_W : default product word width (16x16 multiplier output)
//   MAC_ACC_W  : default accumulator width (must exceed MAC_PROD_W)
//   MAC_CNT_W  : default burst-length field width
//   state_t    : burst controller states
// ---------------------------------------------------------------------------
package mac_pkg;

   localparam int MAC_PROD_W = 32;
   localparam int MAC_ACC_W  = 40;
   localparam int MAC_CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/mac_accumulator_if.sv
// ---------------------------------------------------------------------------
// mac_accumulator_if
// Bundles the burst command, product stream and result handshake.
//   start/len          : burst command (len sampled with start)
//   prod_valid/prod    : upstream product stream, accepted when prod_ready
//   acc_valid/acc_out  : final burst sum, released when acc_ready
//   busy/overflow      : status
// Modports: master drives commands/products, slave is the accumulator.
// ---------------------------------------------------------------------------
interface mac_accumulator_if
   import mac_pkg::*;
#(
   parameter int PROD_W = MAC_PROD_W,
   parameter int ACC_W  = MAC_ACC_W,
   parameter int CNT_W  = MAC_CNT_W
) ();

   logic              start;
   logic [CNT_W-1:0]  len;
   logic              prod_valid;
   logic [PROD_W-1:0] prod;
   logic              prod_ready;
   logic              acc_valid;
   logic              acc_ready;
   logic [ACC_W-1:0]  acc_out;
   logic              busy;
   logic              overflow;

   modport master (
      output start, len, prod_valid, prod, acc_ready,
      input  prod_ready, acc_valid, acc_out, busy, overflow
   );

   modport slave (
      input  start, len, prod_valid, prod, acc_ready,
      output prod_ready, acc_valid, acc_out, busy, overflow
   );

endinterface

// File: rtl/mac_accumulator_sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
// Combinational unsigned saturating adder: sum = a + zero-extended b,
// clamped to all-ones when the true result needs more than ACC_W bits.
//   a   : ACC_W-bit accumulator value
//   b   : PROD_W-bit unsigned product
//   sum : saturated ACC_W-bit result
//   ovf : high when this add saturated
// ---------------------------------------------------------------------------
module sat_add #(
   parameter int PROD_W = 32,
   parameter int ACC_W  = 40
) (
   input  logic [ACC_W-1:0]  a,
   input  logic [PROD_W-1:0] b,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   // One guard bit above the accumulator catches the carry out.
   function automatic logic [ACC_W:0] wide_add(input logic [ACC_W-1:0]  x,
                                                input logic [PROD_W-1:0] y);
      return {1'b0, x} + {{(ACC_W + 1 - PROD_W){1'b0}}, y};
   endfunction

   function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W:0] w);
      return w[ACC_W] ? {ACC_W{1'b1}} : w[ACC_W-1:0];
   endfunction

   logic [ACC_W:0] wide;

   always_comb begin
      wide = wide_add(a, b);
      sum  = saturate(wide);
      ovf  = wide[ACC_W];
   end

endmodule

// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
// Sums a burst of len unsigned products into a saturating accumulator and
// presents the total with a valid/ready handshake.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mac_accumulator_if.slave (command, product stream, result, status)
// Flow: IDLE --start--> ACCUM --last transfer--> HOLD --acc_ready--> IDLE.
// A zero-length start goes straight to HOLD with a zero sum.
// ---------------------------------------------------------------------------
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int PROD_W = MAC_PROD_W,
   parameter int ACC_W  = MAC_ACC_W,
   parameter int CNT_W  = MAC_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   mac_accumulator_if.slave   bus
);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [ACC_W-1:0]  acc;
   logic              ovf_sticky;
   logic [ACC_W-1:0]  add_sum;
   logic              add_ovf;
   logic              prod_ready;
   logic              acc_valid;
   logic              busy;
   logic              xfer;

   sat_add #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_sat_add (
      .a   (acc),
      .b   (bus.prod),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   assign xfer = bus.prod_valid & prod_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      prod_ready = 1'b0;
      acc_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.start)
               state_nxt = (bus.len == '0) ? HOLD : ACCUM;
         end
         ACCUM: begin
            prod_ready = 1'b1;
            if (xfer && cnt == CNT_W'(1))
               state_nxt = HOLD;
         end
         HOLD: begin
            acc_valid = 1'b1;
            // Any start seen here is dropped: the return to IDLE is unconditional.
            if (bus.acc_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accumulator, remaining count and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         cnt        <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  acc        <= '0;
                  cnt        <= bus.len;
                  ovf_sticky <= 1'b0;
               end
            end
            ACCUM: begin
               if (xfer) begin
                  acc        <= add_sum;
                  cnt        <= cnt - CNT_W'(1);
                  ovf_sticky <= ovf_sticky | add_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.prod_ready = prod_ready;
   assign bus.acc_valid  = acc_valid;
   assign bus.busy       = busy;
   assign bus.acc_out    = acc;
   assign bus.overflow   = ovf_sticky;

endmodule
